// File: rtl/joy_db15_tx_if.sv
// joy_db15_tx_if: link-side signal bundle for the DB15 joystick device emulator.
//   joystick1/2  : parallel button words (active-high, map "LS FEDCBAUDLR")
//   JOY_CLK      : host shift clock (asynchronous to the device clock)
//   JOY_LOAD     : host parallel-load strobe, active-low (asynchronous)
//   JOY_DATA     : serial data back to host, active-low
//   load_pulse   : one-cycle pulse on the synchronised JOY_LOAD fall
//   bit_cnt      : shifts since last load, saturating at 2*PLAYER_BITS
// master = the side driving buttons and the host link, slave = the emulator.
interface joy_db15_tx_if #(
    parameter int PLAYER_BITS = 16
);
    logic [PLAYER_BITS-1:0] joystick1;
    logic [PLAYER_BITS-1:0] joystick2;
    logic                   JOY_CLK;
    logic                   JOY_LOAD;
    logic                   JOY_DATA;
    logic                   load_pulse;
    logic [5:0]             bit_cnt;

    modport master (
        output joystick1, joystick2, JOY_CLK, JOY_LOAD,
        input  JOY_DATA, load_pulse, bit_cnt
    );

    modport slave (
        input  joystick1, joystick2, JOY_CLK, JOY_LOAD,
        output JOY_DATA, load_pulse, bit_cnt
    );
endinterface

// File: rtl/joy_db15_tx.sv
// joy_db15_tx: device-side emulator of the DB15 serial joystick adapter.
// Two players of PLAYER_BITS buttons are shifted out LSB-first (player 1
// bit 0 first) as active-low data over the JOY_CLK/JOY_LOAD/JOY_DATA link.
// Ports:
//   clk      : system clock, at least 8x the JOY_CLK rate
//   RESET_L  : asynchronous active-low reset
//   jif      : link bundle (slave side), see joy_db15_tx_if
module joy_db15_tx #(
    parameter int PLAYER_BITS = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           RESET_L,
    joy_db15_tx_if.slave   jif
);
    localparam int         N       = 2 * PLAYER_BITS;
    localparam logic [5:0] CNT_MAX = 6'(N);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_ld_sync;
    logic                   r_clk_hist;
    logic                   r_ld_hist;
    logic [N-1:0]           r_sr;
    logic [5:0]             r_cnt;
    logic                   r_data;
    logic                   r_load_pulse;

    logic w_clk_s;
    logic w_ld_s;
    logic w_clk_rise;
    logic w_ld_fall;
    logic w_loading;

    // Synchronisers and history flops preset high so reset release never
    // looks like a JOY_CLK rise or a JOY_LOAD fall.
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            r_clk_sync <= '1;
            r_ld_sync  <= '1;
            r_clk_hist <= 1'b1;
            r_ld_hist  <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], jif.JOY_CLK};
            r_ld_sync  <= {r_ld_sync[SYNC_STAGES-2:0], jif.JOY_LOAD};
            r_clk_hist <= w_clk_s;
            r_ld_hist  <= w_ld_s;
        end
    end

    assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
    assign w_ld_s     = r_ld_sync[SYNC_STAGES-1];
    assign w_clk_rise = w_clk_s & ~r_clk_hist;
    assign w_ld_fall  = ~w_ld_s & r_ld_hist;
    assign w_loading  = ~w_ld_s;

    // Load is transparent (reloads every cycle while low) and beats a
    // coincident shift. Shifting in 1s makes an overrun read as released.
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            r_sr         <= '1;
            r_cnt        <= '0;
            r_data       <= 1'b1;
            r_load_pulse <= 1'b0;
        end else begin
            if (w_loading) begin
                r_sr  <= ~{jif.joystick2, jif.joystick1};
                r_cnt <= '0;
            end else if (w_clk_rise) begin
                r_sr <= {1'b1, r_sr[N-1:1]};
                if (r_cnt != CNT_MAX)
                    r_cnt <= r_cnt + 6'd1;
            end
            r_data       <= r_sr[0];
            r_load_pulse <= w_ld_fall;
        end
    end

    assign jif.JOY_DATA   = r_data;
    assign jif.load_pulse = r_load_pulse;
    assign jif.bit_cnt    = r_cnt;
endmodule

// File: tb/tb_joy_db15_tx.sv
module tb_joy_db15_tx;
    localparam int PB = 16;
    localparam int SS = 2;
    localparam int N  = 2 * PB;

    logic clk = 1'b0;
    logic RESET_L = 1'b0;
    always #10 clk = ~clk;

    joy_db15_tx_if #(.PLAYER_BITS(PB)) jif();

    joy_db15_tx #(.PLAYER_BITS(PB), .SYNC_STAGES(SS)) dut (
        .clk     (clk),
        .RESET_L (RESET_L),
        .jif     (jif)
    );

    typedef struct {
        logic       d;
        logic [5:0] cnt;
        int         idx;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   lp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: the host samples JOY_DATA on each JOY_CLK rise, like the receiver.
    always begin
        @(posedge jif.JOY_CLK);
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow: JOY_CLK rise with no expected entry");
        end else begin
            mon_e = sbq.pop_front();
            chk($sformatf("data[%0d]", mon_e.idx), {31'd0, jif.JOY_DATA}, {31'd0, mon_e.d});
            chk($sformatf("cnt[%0d]", mon_e.idx), {26'd0, jif.bit_cnt}, {26'd0, mon_e.cnt});
        end
    end

    always @(negedge clk)
        if (jif.load_pulse === 1'b1) lp_cnt++;

    // One host frame: load, then nclk shift clocks of 20 cycles each.
    task automatic frame(input int nclk, input bit lat, input int chg_at,
                         input logic [PB-1:0] chg_val, input int rst_at);
        logic [N-1:0] fr;
        logic         prev;
        int           lp0;
        exp_t         e;
        lp0  = lp_cnt;
        prev = jif.JOY_DATA;
        fr   = ~{jif.joystick2, jif.joystick1};
        @(negedge clk);
        jif.JOY_LOAD = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (lat && c == 2) chk("load_lat_old", {31'd0, jif.JOY_DATA}, {31'd0, prev});
            if (lat && c == 3) chk("load_lat_new", {31'd0, jif.JOY_DATA}, {31'd0, fr[0]});
        end
        jif.JOY_LOAD = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < nclk; i++) begin
            if (i == rst_at) begin
                RESET_L = 1'b0;
                #1;
                chk("rst_mid_data", {31'd0, jif.JOY_DATA}, 32'd1);
                chk("rst_mid_cnt", {26'd0, jif.bit_cnt}, 32'd0);
                @(negedge clk);
                RESET_L = 1'b1;
                repeat (10) @(negedge clk);
                return;
            end
            e.d   = (i < N) ? fr[i] : 1'b1;
            e.cnt = (i < N) ? 6'(i) : 6'(N);
            e.idx = i;
            sbq.push_back(e);
            jif.JOY_CLK = 1'b1;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (lat && i == 0 && c == 2) chk("clk_lat_old", {31'd0, jif.JOY_DATA}, {31'd0, fr[0]});
                if (lat && i == 0 && c == 3) chk("clk_lat_new", {31'd0, jif.JOY_DATA}, {31'd0, fr[1]});
            end
            jif.JOY_CLK = 1'b0;
            repeat (10) @(negedge clk);
            if (i == chg_at) jif.joystick1 = chg_val;
        end
        chk("cnt_end", {26'd0, jif.bit_cnt}, (nclk < N) ? nclk : N);
        chk("data_end", {31'd0, jif.JOY_DATA}, {31'd0, (nclk >= N) ? 1'b1 : fr[nclk]});
        chk("load_pulses", lp_cnt - lp0, 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   lp0;
        jif.JOY_CLK   = 1'b0;
        jif.JOY_LOAD  = 1'b1;
        jif.joystick1 = 16'h0001;
        jif.joystick2 = 16'h8000;
        RESET_L       = 1'b0;
        repeat (4) @(negedge clk);
        RESET_L = 1'b1;
        repeat (20) @(negedge clk);
        chk("reset_data", {31'd0, jif.JOY_DATA}, 32'd1);
        chk("reset_cnt", {26'd0, jif.bit_cnt}, 32'd0);
        chk("reset_no_pulse", lp_cnt, 32'd0);

        // Stream 0,1x30,0 with latency checks on the load and first clock edge.
        frame(N, 1'b1, -1, '0, -1);
        // Overrun: 8 extra clocks read as released, count holds.
        frame(N + 8, 1'b0, -1, '0, -1);
        // Button change after bit 2 shifted: ignored until next load.
        frame(N, 1'b0, 2, 16'h0010, -1);
        frame(N, 1'b0, -1, '0, -1);
        chk("new_frame_j1", {16'd0, jif.joystick1}, 32'h0010);

        // Transparent load: JOY_DATA tracks ~joystick1[0], clocks ignored.
        lp0 = lp_cnt;
        @(negedge clk);
        jif.JOY_LOAD = 1'b0;
        repeat (8) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            jif.joystick1[0] = k[0];
            repeat (6) @(negedge clk);
            e.d   = ~k[0];
            e.cnt = 6'd0;
            e.idx = 100 + k;
            sbq.push_back(e);
            jif.JOY_CLK = 1'b1;
            repeat (6) @(negedge clk);
            jif.JOY_CLK = 1'b0;
            repeat (6) @(negedge clk);
        end
        jif.JOY_LOAD = 1'b1;
        repeat (10) @(negedge clk);
        chk("hold_cnt", {26'd0, jif.bit_cnt}, 32'd0);
        chk("hold_pulses", lp_cnt - lp0, 32'd1);

        // Random button frames.
        for (int f = 0; f < 5; f++) begin
            jif.joystick1 = 16'($urandom);
            jif.joystick2 = 16'($urandom);
            frame(N, 1'b0, -1, '0, -1);
        end

        // Reset mid-frame, then a clean frame.
        jif.joystick1 = 16'hA5C3;
        jif.joystick2 = 16'h1E7F;
        frame(N, 1'b0, -1, '0, 10);
        chk("post_rst_cnt", {26'd0, jif.bit_cnt}, 32'd0);
        frame(N, 1'b0, -1, '0, -1);

        chk("sb_empty", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
